// File: rtl/csr_access_unit_pkg.sv
// Shared CSR definitions: operation encoding, funct3 field layout and FSM states.
package csr_access_unit_pkg;

  // funct3[1:0] encoding; OpNone is the reserved/invalid value.
  typedef enum logic [1:0] {
    OpNone = 2'b00,
    OpRw   = 2'b01,
    OpRs   = 2'b10,
    OpRc   = 2'b11
  } csr_op_t;

  // funct3 field layout.
  localparam int unsigned Funct3ImmBit = 2;
  localparam int unsigned Funct3OpMsb  = 1;
  localparam int unsigned Funct3OpLsb  = 0;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StResp
  } csr_state_e;

  function automatic csr_op_t funct3_to_op(input logic [2:0] funct3);
    return csr_op_t'(funct3[Funct3OpMsb:Funct3OpLsb]);
  endfunction

endpackage

// File: rtl/csr_alu.sv
// Write-value computation for CSRRW/CSRRS/CSRRC.
module csr_alu
  import csr_access_unit_pkg::*;
(
  input  csr_op_t     op_i,
  input  logic [31:0] src_i,
  input  logic [31:0] old_i,
  output logic [31:0] wdata_o
);

  // Select the new CSR value from the operand and the previously read value.
  always_comb begin
    wdata_o = '0;
    case (op_i)
      OpRw:    wdata_o = src_i;
      OpRs:    wdata_o = old_i | src_i;
      OpRc:    wdata_o = old_i & ~src_i;
      default: wdata_o = '0;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// Sequences one CSR instruction: optional read, optional write, then writeback response.
module csr_access_unit
  import csr_access_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_csr_addr,
  input  logic [4:0]  req_rs1_idx,
  input  logic [31:0] req_rs1_value,
  input  logic [4:0]  req_rd_idx,
  output logic        csr_read,
  output logic        csr_write,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  input  logic        csr_illegal,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [4:0]  resp_rd_idx,
  output logic [31:0] resp_rd_value,
  output logic        resp_rd_write,
  output logic        resp_exception
);

  csr_state_e  state_q, state_d;
  csr_op_t     op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [4:0]  rd_idx_q, rd_idx_d;
  logic [31:0] src_q, src_d;
  logic [31:0] old_q, old_d;
  logic        do_write_q, do_write_d;
  logic        exc_q, exc_d;

  csr_op_t     req_op;
  logic        req_do_read;
  logic        req_do_write;
  logic [31:0] alu_wdata;

  // Decode the offered request into operation and read/write decisions.
  always_comb begin
    req_op       = funct3_to_op(req_funct3);
    // RW with rd=x0 must not read; RS/RC with a zero source field must not write.
    req_do_read  = !((req_op == OpRw) && (req_rd_idx == 5'd0));
    req_do_write = (req_op == OpRw) || (req_rs1_idx != 5'd0);
  end

  csr_alu u_csr_alu (
    .op_i    (op_q),
    .src_i   (src_q),
    .old_i   (old_q),
    .wdata_o (alu_wdata)
  );

  // Next-state logic for the FSM and the per-request context.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    rd_idx_d   = rd_idx_q;
    src_d      = src_q;
    old_d      = old_q;
    do_write_d = do_write_q;
    exc_d      = exc_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d       = req_op;
          addr_d     = req_csr_addr;
          rd_idx_d   = req_rd_idx;
          src_d      = req_funct3[Funct3ImmBit] ? {27'd0, req_rs1_idx} : req_rs1_value;
          // Cleared so a request that never reads returns zero.
          old_d      = '0;
          do_write_d = req_do_write;
          exc_d      = 1'b0;
          if (req_op == OpNone) begin
            exc_d   = 1'b1;
            state_d = StResp;
          end else if (req_do_read) begin
            state_d = StRead;
          end else begin
            state_d = StWrite;
          end
        end
      end
      StRead: begin
        old_d = csr_rdata;
        if (csr_illegal) begin
          exc_d   = 1'b1;
          state_d = StResp;
        end else if (do_write_q) begin
          state_d = StWrite;
        end else begin
          state_d = StResp;
        end
      end
      StWrite: begin
        if (csr_illegal) begin
          exc_d = 1'b1;
        end
        state_d = StResp;
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and context registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= OpNone;
      addr_q     <= '0;
      rd_idx_q   <= '0;
      src_q      <= '0;
      old_q      <= '0;
      do_write_q <= 1'b0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      rd_idx_q   <= rd_idx_d;
      src_q      <= src_d;
      old_q      <= old_d;
      do_write_q <= do_write_d;
      exc_q      <= exc_d;
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    req_ready      = (state_q == StIdle);
    csr_read       = (state_q == StRead);
    csr_write      = (state_q == StWrite);
    csr_addr       = addr_q;
    csr_wdata      = (state_q == StWrite) ? alu_wdata : '0;
    resp_valid     = (state_q == StResp);
    resp_rd_idx    = rd_idx_q;
    resp_rd_value  = old_q;
    resp_exception = (state_q == StResp) && exc_q;
    resp_rd_write  = (state_q == StResp) && !exc_q && (rd_idx_q != 5'd0);
  end

endmodule

// File: doc/csr_access_unit.md
CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 The block SHALL use a single clock; reset is synchronous and active-high.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  decoded CSR instruction offered.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_funct3  input  3  instr[14:12]: bit2 = immediate source, bits[1:0] = 01 RW, 10 RS, 11 RC.
REQ-007 req_csr_addr  input  12  instr[31:20].
REQ-008 req_rs1_idx  input  5  rs1 field; doubles as uimm when funct3[2]=1.
REQ-009 req_rs1_value  input  32  rs1 register value.
REQ-010 req_rd_idx  input  5  destination register index.
REQ-011 csr_read  output  1  read strobe to CSR file.
REQ-012 csr_write  output  1  write strobe to CSR file.
REQ-013 csr_addr  output  12  CSR address, held from accept to response.
REQ-014 csr_wdata  output  32  value to write.
REQ-015 csr_rdata  input  32  combinational read value from CSR file.
REQ-016 csr_illegal  input  1  CSR file illegal-access flag, valid in the same cycle as the strobe.
REQ-017 resp_valid / resp_ready  output / input  1 / 1  writeback handshake.
REQ-018 resp_rd_idx, resp_rd_value, resp_rd_write  output  5 / 32 / 1  writeback data, valid while resp_valid is high.
REQ-019 resp_exception  output  1  illegal-instruction exception, qualified by resp_valid.

Function
REQ-020 FSM states SHALL be IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-021 On accept (IDLE, req_valid=1), the unit SHALL latch funct3, addr, rd_idx and the source operand (funct3[2] ? zero-extended rs1_idx : rs1_value).
REQ-022 Decision flags: do_read = !(RW && rd_idx==0); do_write = RW || (source field rs1_idx != 0).
REQ-023 funct3[1:0]=00 SHALL go IDLE->RESP with resp_exception=1, no strobes.
REQ-024 Next state after accept SHALL be READ if do_read, else WRITE.
REQ-025 READ: csr_read=1 for exactly one cycle; the unit SHALL capture csr_rdata and csr_illegal; illegal -> RESP with exception; else WRITE if do_write, else RESP.
REQ-026 WRITE: csr_write=1 for exactly one cycle, with csr_wdata = src (RW), old|src (RS), old&~src (RC); old = captured read value.
REQ-027 A csr_illegal in WRITE SHALL set the exception; the next state SHALL be RESP regardless.
REQ-028 RESP: resp_valid=1 is held with stable data until resp_ready=1, then IDLE; resp_rd_write = !exception && rd_idx!=0; resp_rd_value = captured old value (0 if not read).
REQ-029 csr_read and csr_write SHALL never be high together; neither SHALL be high outside READ/WRITE.
REQ-030 Latency from accept to resp_valid SHALL be 3 cycles for read+write, 2 cycles for single access, and 1 cycle for an invalid funct3.
REQ-031 Back-to-back: the cycle after a resp handshake, the unit SHALL be in IDLE and can accept.

Reset
REQ-032 Reset SHALL force IDLE; req_ready=1; csr_read, csr_write, resp_valid, resp_exception, resp_rd_write=0; csr_addr, csr_wdata, resp_rd_value=0.
REQ-033 Reset mid-operation SHALL abandon the request with no strobe in the following cycle and no response.

Structure
REQ-034 The shared CSR package SHALL hold csr_op_t (RW/RS/RC), the funct3 field constants, and the state enum.
REQ-035 The RW/RS/RC write-value computation SHALL be one combinational sub-module, csr_alu.

Verification
REQ-036 CSRRS rd=5, rs1=0, addr=0xC00, rdata=0x1234 -> one csr_read, no csr_write, resp rd=5 value 0x1234 at cycle 2.
REQ-037 CSRRC src=0x0F, old=0xFF -> csr_write with wdata 0xF0 at cycle 2; resp at cycle 3 carrying 0xFF.
REQ-038 CSRRWI rd=0, uimm=7 -> no read, csr_write wdata 0x7, resp_rd_write=0.
REQ-039 CSRRW to 0xC00 with csr_illegal=1 in READ -> no write, resp_exception=1, resp_rd_write=0.
REQ-040 resp_ready held low 4 cycles -> resp data stable, req_ready=0 throughout; accepted next request the cycle after the handshake.
REQ-041 Reset asserted in WRITE -> IDLE next cycle; no resp_valid.
